// File: rtl/mem_stage_sram_ctrl_pkg.sv
// rtl/mem_stage_sram_ctrl_pkg.sv - shared widths and FSM encodings for the MEM-stage SRAM controller
package mem_stage_sram_ctrl_pkg;

  localparam int LEN_REGISTER     = 32;
  localparam int LEN_SRAM_DATA    = 16;
  localparam int LEN_SRAM_ADDRESS = 18;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_LO   = 2'd1,
    MEM_ST_HI   = 2'd2,
    MEM_ST_DONE = 2'd3
  } mem_state_e;

  // Counter width able to hold 0..wait_cycles-1.
  function automatic int wait_cnt_width(input int wait_cycles);
    return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
  endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// rtl/mem_stage_sram_ctrl_if.sv - EX/MEM request and ready/read_data response bundle
interface mem_stage_sram_ctrl_if;
  import mem_stage_sram_ctrl_pkg::*;

  logic                    mem_read;
  logic                    mem_write;
  logic [LEN_REGISTER-1:0] address;
  logic [LEN_REGISTER-1:0] write_data;
  logic                    ready;
  logic [LEN_REGISTER-1:0] read_data;

  modport master (
    output mem_read, mem_write, address, write_data,
    input  ready, read_data
  );

  modport slave (
    input  mem_read, mem_write, address, write_data,
    output ready, read_data
  );

endinterface

// File: rtl/sram_read_buffer.sv
// rtl/sram_read_buffer.sv - one-entry {valid, word, data} load buffer, used only under SRAM_READ_BUF_EN
module sram_read_buffer
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int WORD_W = LEN_SRAM_ADDRESS - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fill_en,
  input  logic                    wr_en,
  input  logic [WORD_W-1:0]       upd_word,
  input  logic [LEN_REGISTER-1:0] upd_data,
  input  logic [WORD_W-1:0]       lookup_word,
  output logic                    hit,
  output logic [LEN_REGISTER-1:0] hit_data
);

  logic                    valid_q;
  logic [WORD_W-1:0]       word_q;
  logic [LEN_REGISTER-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      data_q  <= '0;
    end else if (fill_en) begin
      valid_q <= 1'b1;
      word_q  <= upd_word;
      data_q  <= upd_data;
    end else if (wr_en && valid_q && (word_q == upd_word)) begin
      // Stores keep the cached copy coherent instead of invalidating it.
      data_q  <= upd_data;
    end
  end

  assign hit      = valid_q && (word_q == lookup_word);
  assign hit_data = data_q;

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - MEM-stage 32-bit load/store over a 16-bit async SRAM in two half-word accesses
// Optional one-entry read buffer enabled by defining SRAM_READ_BUF_EN.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 2,
  parameter int          SRAM_AW     = LEN_SRAM_ADDRESS
) (
  input  logic                      clk,
  input  logic                      rst,
  mem_stage_sram_ctrl_if.slave      bus,
  output logic [SRAM_AW-1:0]        sram_addr,
  inout  wire  [LEN_SRAM_DATA-1:0]  sram_dq,
  output logic                      sram_we_n,
  output logic                      sram_oe_n
);

  localparam int                WORD_W    = SRAM_AW - 1;
  localparam int                CNT_W     = wait_cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

  mem_state_e              state, state_nxt;
  logic [CNT_W-1:0]        wait_cnt;
  logic                    op_write;
  logic [WORD_W-1:0]       lat_word;
  logic [LEN_REGISTER-1:0] lat_wdata;
  logic [LEN_SRAM_DATA-1:0] lo_half;
  logic [LEN_REGISTER-1:0] read_data_q;

  logic [31:0]             offset;
  logic [WORD_W-1:0]       req_word;
  logic                    req;
  logic                    in_access;
  logic                    last_wait;
  logic                    rd_hit;
  logic [LEN_REGISTER-1:0] hit_data;
  logic                    dq_drive;
  logic [LEN_SRAM_DATA-1:0] dq_out;
  logic                    unused_addr_bits;

  assign offset           = bus.address - BASE_ADDR;
  assign req_word         = offset[SRAM_AW:2];
  assign unused_addr_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};
  assign req              = bus.mem_read | bus.mem_write;
  assign in_access        = (state == MEM_ST_LO) || (state == MEM_ST_HI);
  assign last_wait        = (wait_cnt == WAIT_LAST);

`ifdef SRAM_READ_BUF_EN
  logic buf_hit;

  sram_read_buffer #(.WORD_W(WORD_W)) u_read_buffer (
    .clk         (clk),
    .rst         (rst),
    .fill_en     ((state == MEM_ST_HI) && last_wait && !op_write),
    .wr_en       ((state == MEM_ST_HI) && last_wait && op_write),
    .upd_word    (lat_word),
    .upd_data    (op_write ? lat_wdata : {sram_dq, lo_half}),
    .lookup_word (req_word),
    .hit         (buf_hit),
    .hit_data    (hit_data)
  );

  // Stores always go to the SRAM, so only a pure load may short-circuit.
  assign rd_hit = buf_hit && bus.mem_read && !bus.mem_write;
`else
  assign rd_hit   = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      MEM_ST_IDLE: if (req)       state_nxt = rd_hit ? MEM_ST_DONE : MEM_ST_LO;
      MEM_ST_LO:   if (last_wait) state_nxt = MEM_ST_HI;
      MEM_ST_HI:   if (last_wait) state_nxt = MEM_ST_DONE;
      MEM_ST_DONE:                state_nxt = MEM_ST_IDLE;
      default:                    state_nxt = MEM_ST_IDLE;
    endcase
  end

  always_comb begin
    sram_addr = '0;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b1;
    dq_drive  = 1'b0;
    dq_out    = '0;
    if (in_access) begin
      sram_addr = {lat_word, state == MEM_ST_HI};
      sram_we_n = !op_write;
      sram_oe_n = op_write;
      dq_drive  = op_write;
      dq_out    = (state == MEM_ST_HI) ? lat_wdata[31:16] : lat_wdata[15:0];
    end
  end

  assign sram_dq       = dq_drive ? dq_out : {LEN_SRAM_DATA{1'bz}};
  assign bus.ready     = (state == MEM_ST_DONE) || ((state == MEM_ST_IDLE) && !req);
  assign bus.read_data = read_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= MEM_ST_IDLE;
      wait_cnt    <= '0;
      op_write    <= 1'b0;
      lat_word    <= '0;
      lat_wdata   <= '0;
      lo_half     <= '0;
      read_data_q <= '0;
    end else begin
      state <= state_nxt;

      if (in_access && !last_wait) wait_cnt <= wait_cnt + 1'b1;
      else                         wait_cnt <= '0;

      // Inputs are only sampled here; LO/HI work from the latched copies.
      if ((state == MEM_ST_IDLE) && req) begin
        op_write  <= bus.mem_write;
        lat_word  <= req_word;
        lat_wdata <= bus.write_data;
        if (rd_hit) read_data_q <= hit_data;
      end

      if ((state == MEM_ST_LO) && last_wait && !op_write) lo_half <= sram_dq;
      if ((state == MEM_ST_HI) && last_wait && !op_write) read_data_q <= {sram_dq, lo_half};
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb/tb_mem_stage_sram_ctrl.sv - directed scoreboard bench for mem_stage_sram_ctrl (optionally with SRAM_READ_BUF_EN)
module tb_mem_stage_sram_ctrl;

  localparam int WAIT = 2;
  localparam int FULL = 2 * WAIT + 1;
`ifdef SRAM_READ_BUF_EN
  localparam int HIT_LAT = 1;
  localparam bit HIT_OE  = 1'b0;
`else
  localparam int HIT_LAT = FULL;
  localparam bit HIT_OE  = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic [15:0] sram_mem [0:255];

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb [$];

  mem_stage_sram_ctrl_if bus();

  mem_stage_sram_ctrl #(
    .BASE_ADDR   (32'd1024),
    .WAIT_CYCLES (WAIT),
    .SRAM_AW     (18)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sram_addr (sram_addr),
    .sram_dq   (sram_dq),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n)
  );

  always #5 clk = ~clk;

  assign sram_dq = (!sram_oe_n && sram_we_n) ? sram_mem[sram_addr[7:0]] : 16'hzzzz;

  always @(negedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr[7:0]] <= sram_dq;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that leaves DONE.
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input int exp_edges, input bit exp_oe, input string tag);
    int edges = 0;
    bit saw_we = 1'b0;
    bit saw_oe = 1'b0;
    bit done = 1'b0;
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.address    = a;
    bus.write_data = d;
    while (!done && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (!sram_we_n) saw_we = 1'b1;
      if (!sram_oe_n) saw_oe = 1'b1;
      done = bus.ready;
    end
    chk({tag, "_latency"}, edges, exp_edges);
    chk({tag, "_we_pulse"}, {31'd0, saw_we}, {31'd0, wr});
    chk({tag, "_oe_pulse"}, {31'd0, saw_oe}, {31'd0, exp_oe});
    if (rd && !wr) begin
      if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      else                chk({tag, "_read_data"}, bus.read_data, sb.pop_front());
    end
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sram_mem[i] = 16'h0000;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.address    = 32'd0;
    bus.write_data = 32'd0;

    repeat (2) @(negedge clk);
    chk("reset_ready", {31'd0, bus.ready}, 32'd1);
    chk("reset_pins", {12'd0, sram_we_n, sram_oe_n, sram_addr}, {12'd0, 2'b11, 18'd0});
    chk("reset_read_data", bus.read_data, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // No access: ready every cycle, pins idle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_ready", {31'd0, bus.ready}, 32'd1);
      chk("idle_pins", {12'd0, sram_we_n, sram_oe_n, sram_addr}, {12'd0, 2'b11, 18'd0});
    end
    @(posedge clk);
    #1;

    do_access(1'b0, 1'b1, 32'd1024, 32'h12345678, FULL, 1'b0, "store0");
    chk("store0_sram0", {16'd0, sram_mem[0]}, 32'h5678);
    chk("store0_sram1", {16'd0, sram_mem[1]}, 32'h1234);

    sb.push_back(32'h12345678);
    do_access(1'b1, 1'b0, 32'd1024, 32'd0, FULL, 1'b1, "load0");

    // Back-to-back store/load at the next word, one IDLE cycle between them.
    do_access(1'b0, 1'b1, 32'd1028, 32'hAABBCCDD, FULL, 1'b0, "store1");
    chk("store1_sram2", {16'd0, sram_mem[2]}, 32'hCCDD);
    chk("store1_sram3", {16'd0, sram_mem[3]}, 32'hAABB);
    sb.push_back(32'hAABBCCDD);
    do_access(1'b1, 1'b0, 32'd1028, 32'd0, FULL, 1'b1, "load1");

    // Byte offset bits are ignored; same word, so a buffer hit when enabled.
    sb.push_back(32'hAABBCCDD);
    do_access(1'b1, 1'b0, 32'd1031, 32'd0, HIT_LAT, HIT_OE, "load1_unaligned");

    // Read and write together: write wins, no output-enable pulse.
    do_access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, FULL, 1'b0, "rw_both");
    chk("rw_both_sram4", {16'd0, sram_mem[4]}, 32'hF00D);
    chk("rw_both_sram5", {16'd0, sram_mem[5]}, 32'hCAFE);
    chk("read_data_held", bus.read_data, 32'hAABBCCDD);

    // Reset during HI of a store to word 1.
    bus.mem_write  = 1'b1;
    bus.address    = 32'd1028;
    bus.write_data = 32'h11112222;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.mem_write = 1'b0;
    #1;
    chk("midrst_pins", {12'd0, sram_we_n, sram_oe_n, sram_addr}, {12'd0, 2'b11, 18'd0});
    chk("midrst_read_data", bus.read_data, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {31'd0, bus.ready}, 32'd1);
    chk("midrst_sram2", {16'd0, sram_mem[2]}, 32'h2222);
    chk("midrst_sram3", {16'd0, sram_mem[3]}, 32'hAABB);
    @(posedge clk);
    #1;

    // Repeat loads, then a store to the buffered word.
    sb.push_back(32'h12345678);
    do_access(1'b1, 1'b0, 32'd1024, 32'd0, FULL, 1'b1, "buf_load_a");
    sb.push_back(32'h12345678);
    do_access(1'b1, 1'b0, 32'd1024, 32'd0, HIT_LAT, HIT_OE, "buf_load_b");
    do_access(1'b0, 1'b1, 32'd1024, 32'h00000000, FULL, 1'b0, "buf_store");
    sb.push_back(32'h00000000);
    do_access(1'b1, 1'b0, 32'd1024, 32'd0, HIT_LAT, HIT_OE, "buf_load_c");

    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
